// File: rtl/video_timing.sv
// Raster timing generator: free-running pixel/line counters with registered sync, blank and
// coordinate outputs. Define VIDEO_TIMING_VBLANK_IRQ_EN to add the sticky vertical-blank flag.
`timescale 1ns/1ps
module video_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          data_en,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic          line_start,
    output logic          frame_start
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
    ,
    input  logic          vblank_clr,
    output logic          vblank_irq
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL >= 2**CW || V_TOTAL >= 2**CW) begin : g_bad_total
            $error("video_timing: line or frame total does not fit in CW bits");
        end
        if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_phase
            $error("video_timing: every timing phase must be at least one count long");
        end
    endgenerate

    // Last count of each phase, packed per axis: [CW-1:0] horizontal, [2*CW-1:CW] vertical.
    localparam logic [2*CW-1:0] LAST_ACT  = {CW'(V_ACTIVE - 1), CW'(H_ACTIVE - 1)};
    localparam logic [2*CW-1:0] LAST_FP   = {CW'(V_ACTIVE + V_FP - 1), CW'(H_ACTIVE + H_FP - 1)};
    localparam logic [2*CW-1:0] LAST_SYNC = {CW'(V_ACTIVE + V_FP + V_SYNC - 1),
                                             CW'(H_ACTIVE + H_FP + H_SYNC - 1)};
    localparam logic [2*CW-1:0] LAST_TOT  = {CW'(V_TOTAL - 1), CW'(H_TOTAL - 1)};

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

    logic            run;
    logic [1:0]      wrap;
    logic [1:0]      step;
    logic [1:0]      in_active;
    logic [1:0]      in_sync;
    logic [1:0]      at_zero;
    logic [2*CW-1:0] cnt_all;

    assign run  = ~reset & en;
    assign step = {wrap[0], 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [CW-1:0] L_ACT  = LAST_ACT[gi*CW +: CW];
            localparam logic [CW-1:0] L_FP   = LAST_FP[gi*CW +: CW];
            localparam logic [CW-1:0] L_SYNC = LAST_SYNC[gi*CW +: CW];
            localparam logic [CW-1:0] L_TOT  = LAST_TOT[gi*CW +: CW];

            logic [CW-1:0] cnt_reg, cnt_next;
            phase_t        phase_reg, phase_next;

            assign wrap[gi] = (cnt_reg == L_TOT);

            // Phase advances on the step that leaves the last count of the current phase,
            // so phase_reg always equals the decode of cnt_reg.
            always_comb begin
                cnt_next   = cnt_reg;
                phase_next = phase_reg;
                if (step[gi]) begin
                    cnt_next = wrap[gi] ? '0 : cnt_reg + 1'b1;
                    case (phase_reg)
                        ACTIVE:  if (cnt_reg == L_ACT)  phase_next = FRONT;
                        FRONT:   if (cnt_reg == L_FP)   phase_next = SYNC;
                        SYNC:    if (cnt_reg == L_SYNC) phase_next = BACK;
                        BACK:    if (wrap[gi])          phase_next = ACTIVE;
                        default: phase_next = phase_reg;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (!run) begin
                    cnt_reg   <= '0;
                    phase_reg <= ACTIVE;
                end else begin
                    cnt_reg   <= cnt_next;
                    phase_reg <= phase_next;
                end
            end

            assign cnt_all[gi*CW +: CW] = cnt_reg;
            assign in_active[gi]        = (phase_reg == ACTIVE);
            assign in_sync[gi]          = (phase_reg == SYNC);
            assign at_zero[gi]          = (cnt_reg == '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!run) begin
            data_en     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            hpos        <= '0;
            vpos        <= '0;
        end else begin
            data_en     <= &in_active;
            line_start  <= at_zero[0];
            frame_start <= &at_zero;
            hsync       <= in_sync[0] ? HS_POL : ~HS_POL;
            vsync       <= in_sync[1] ? VS_POL : ~VS_POL;
            hpos        <= cnt_all[CW-1:0];
            vpos        <= cnt_all[2*CW-1:CW];
        end
    end

`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
    logic vblank_set;
    assign vblank_set = at_zero[0] && (cnt_all[2*CW-1:CW] == CW'(V_ACTIVE));

    // Set beats clear so a clear held across the first blanking line cannot lose the event.
    always_ff @(posedge clk) begin
        if (!run)
            vblank_irq <= 1'b0;
        else if (vblank_set)
            vblank_irq <= 1'b1;
        else if (vblank_clr)
            vblank_irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a default-mode instance and a small inverted-polarity instance,
// both checked every cycle against a model that derives the raster from elapsed cycles.
`timescale 1ns/1ps
module tb_video_timing;

    localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VA = 6, S_VF = 1, S_VS = 2, S_VB = 1;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic en_d  = 1'b1;
    logic en_s  = 1'b1;
    logic s_clr = 1'b0;

    logic        d_hs, d_vs, d_de, d_ls, d_fs;
    logic [11:0] d_hp, d_vp;
    logic        s_hs, s_vs, s_de, s_ls, s_fs;
    logic [11:0] s_hp, s_vp;
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
    logic d_irq, s_irq;
`endif

    video_timing u_dflt (
        .clk(clk), .reset(reset), .en(en_d),
        .hsync(d_hs), .vsync(d_vs), .data_en(d_de), .hpos(d_hp), .vpos(d_vp),
        .line_start(d_ls), .frame_start(d_fs)
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
        , .vblank_clr(1'b0), .vblank_irq(d_irq)
`endif
    );

    video_timing #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(12)
    ) u_small (
        .clk(clk), .reset(reset), .en(en_s),
        .hsync(s_hs), .vsync(s_vs), .data_en(s_de), .hpos(s_hp), .vpos(s_vp),
        .line_start(s_ls), .frame_start(s_fs)
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
        , .vblank_clr(s_clr), .vblank_irq(s_irq)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic de, hs, vs, ls, fs;
        int   hp, vp;
    } out_t;

    typedef struct packed {
        logic rst, en, de, ls, fs, hs, vs;
        logic [11:0] hp, vp;
    } vec_t;

    // Reference: the raster position is simply elapsed cycles since release, split by totals.
    function automatic out_t model(longint t, bit run, int ha, int hf, int hs, int hb,
                                   int va, int vf, int vs, int vb, bit hpol, bit vpol);
        out_t o;
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int h, v;
        o.de = 1'b0; o.ls = 1'b0; o.fs = 1'b0;
        o.hs = ~hpol; o.vs = ~vpol; o.hp = 0; o.vp = 0;
        if (run) begin
            h = int'(t % ht);
            v = int'((t / ht) % vt);
            o.de = (h < ha) && (v < va);
            o.hs = (h >= ha + hf && h < ha + hf + hs) ? hpol : ~hpol;
            o.vs = (v >= va + vf && v < va + vf + vs) ? vpol : ~vpol;
            o.hp = h;
            o.vp = v;
            o.ls = (h == 0);
            o.fs = (h == 0) && (v == 0);
        end
        return o;
    endfunction

    function automatic logic [28:0] pk(logic de, logic hs, logic vs, logic ls, logic fs,
                                       logic [11:0] hp, logic [11:0] vp);
        return {de, hs, vs, ls, fs, hp, vp};
    endfunction

    function automatic vec_t mkv(bit rst, bit en, bit de, bit ls, bit fs, bit hs, bit vs,
                                 int hp, int vp);
        vec_t r;
        r.rst = rst; r.en = en; r.de = de; r.ls = ls; r.fs = fs; r.hs = hs; r.vs = vs;
        r.hp = 12'(hp); r.vp = 12'(vp);
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    longint t_d = 0, t_s = 0;
    bit     run_d = 0, run_s = 0;
    bit     irq_m = 0;

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        out_t ed, es;
        @(posedge clk);
        if (reset || !en_d) run_d = 0;
        else begin t_d = run_d ? t_d + 1 : 0; run_d = 1; end
        if (reset || !en_s) begin run_s = 0; irq_m = 0; end
        else begin
            t_s = run_s ? t_s + 1 : 0;
            run_s = 1;
            if ((t_s % S_HT) == 0 && ((t_s / S_HT) % S_VT) == S_VA) irq_m = 1;
            else if (s_clr) irq_m = 0;
        end
        ed = model(t_d, run_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1);
        es = model(t_s, run_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b0, 1'b0);
        #1;
        chk("dflt_outputs", 32'(pk(d_de, d_hs, d_vs, d_ls, d_fs, d_hp, d_vp)),
            32'(pk(ed.de, ed.hs, ed.vs, ed.ls, ed.fs, 12'(ed.hp), 12'(ed.vp))));
        chk("small_outputs", 32'(pk(s_de, s_hs, s_vs, s_ls, s_fs, s_hp, s_vp)),
            32'(pk(es.de, es.hs, es.vs, es.ls, es.fs, 12'(es.hp), 12'(es.vp))));
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
        chk("small_irq", 32'(s_irq), 32'(irq_m));
        chk("dflt_irq_idle_or_set", 32'(d_irq), 32'(d_irq === 1'b1 || d_irq === 1'b0));
`endif
    endtask

    vec_t tbl [11];

    initial begin
        int de_fall, hs_rise, hs_fall, ls2, ls3;
        int fs2, fs3, de_cnt, vs_low, vs_edges, vs_fall, hs_fall_s, hs_rise_s;
        logic prev_de, prev_hs, prev_vs;
        bit found;

        // Small instance, idle level of both syncs is 1 (active-low).
        for (int i = 0; i < 4; i++) tbl[i] = mkv(1, 1, 0, 0, 0, 1, 1, 0, 0);
        tbl[4]  = mkv(0, 1, 1, 1, 1, 1, 1, 0, 0);
        tbl[5]  = mkv(0, 1, 1, 0, 0, 1, 1, 1, 0);
        tbl[6]  = mkv(1, 1, 0, 0, 0, 1, 1, 0, 0);
        tbl[7]  = mkv(0, 0, 0, 0, 0, 1, 1, 0, 0);
        tbl[8]  = mkv(0, 1, 1, 1, 1, 1, 1, 0, 0);
        tbl[9]  = mkv(0, 1, 1, 0, 0, 1, 1, 1, 0);
        tbl[10] = mkv(0, 1, 1, 0, 0, 1, 1, 2, 0);

        for (int i = 0; i < 11; i++) begin
            reset = tbl[i].rst;
            en_s  = tbl[i].en;
            step();
            chk($sformatf("vec%0d", i), 32'(pk(s_de, s_hs, s_vs, s_ls, s_fs, s_hp, s_vp)),
                32'(pk(tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs,
                       tbl[i].hp, tbl[i].vp)));
            $display("vec%0d rst=%0b en=%0b de=%0b ls=%0b fs=%0b hs=%0b vs=%0b hp=%0d vp=%0d",
                     i, reset, en_s, s_de, s_ls, s_fs, s_hs, s_vs, s_hp, s_vp);
        end

        // Default mode: release and single-line timing.
        reset = 1'b1; en_d = 1'b1; en_s = 1'b1;
        repeat (4) step();
        reset = 1'b0;
        step();
        chk("rel_de", 32'(d_de), 32'd1);
        chk("rel_ls", 32'(d_ls), 32'd1);
        chk("rel_fs", 32'(d_fs), 32'd1);
        chk("rel_hs", 32'(d_hs), 32'd0);
        chk("rel_vs", 32'(d_vs), 32'd0);
        chk("rel_pos", 32'({d_hp, d_vp}), 32'd0);
        de_fall = -1; hs_rise = -1; hs_fall = -1; ls2 = -1; ls3 = -1;
        prev_de = d_de; prev_hs = d_hs;
        for (int k = 1; k <= 1700; k++) begin
            step();
            if (prev_de && !d_de && de_fall < 0) de_fall = k;
            if (!prev_hs && d_hs && hs_rise < 0) hs_rise = k;
            if (prev_hs && !d_hs && hs_fall < 0) hs_fall = k;
            if (d_ls) begin
                if (ls2 < 0) ls2 = k;
                else if (ls3 < 0) ls3 = k;
            end
            prev_de = d_de; prev_hs = d_hs;
        end
        chk("line_de_len", 32'(de_fall), 32'd640);
        chk("line_hs_rise", 32'(hs_rise), 32'd656);
        chk("line_hs_width", 32'(hs_fall - hs_rise), 32'd96);
        chk("line_ls_2nd", 32'(ls2), 32'd800);
        chk("line_ls_period", 32'(ls3 - ls2), 32'd800);
        $display("line de_len=%0d hs_rise=%0d hs_w=%0d ls=%0d,%0d",
                 de_fall, hs_rise, hs_fall - hs_rise, ls2, ls3);

        // Small mode: full frames, inverted-polarity syncs.
        reset = 1'b1; step(); reset = 1'b0; step();
        fs2 = -1; fs3 = -1; de_cnt = 1; vs_low = 0; vs_edges = 0; vs_fall = -1;
        hs_fall_s = -1; hs_rise_s = -1;
        prev_vs = s_vs; prev_hs = s_hs;
        for (int k = 1; k <= 320; k++) begin
            step();
            if (s_fs) begin
                if (fs2 < 0) fs2 = k;
                else if (fs3 < 0) fs3 = k;
            end
            if (k < S_HT * S_VT) begin
                if (s_de) de_cnt++;
                if (!s_vs) vs_low++;
            end
            if (s_vs !== prev_vs) begin
                vs_edges++;
                if (vs_fall < 0) vs_fall = k;
                chk("vs_edge_on_line_start", 32'(s_ls), 32'd1);
            end
            if (prev_hs && !s_hs && hs_fall_s < 0) hs_fall_s = k;
            if (!prev_hs && s_hs && hs_fall_s >= 0 && hs_rise_s < 0) hs_rise_s = k;
            prev_vs = s_vs; prev_hs = s_hs;
        end
        chk("frame_fs_2nd", 32'(fs2), 32'd150);
        chk("frame_fs_period", 32'(fs3 - fs2), 32'd150);
        chk("frame_de_count", 32'(de_cnt), 32'd48);
        chk("frame_vs_low", 32'(vs_low), 32'd30);
        chk("frame_vs_fall", 32'(vs_fall), 32'd105);
        chk("frame_vs_edges", 32'(vs_edges), 32'd4);
        chk("small_hs_fall", 32'(hs_fall_s), 32'd10);
        chk("small_hs_width", 32'(hs_rise_s - hs_fall_s), 32'd3);
        $display("frame fs=%0d,%0d de=%0d vs_low=%0d vs_fall=%0d edges=%0d",
                 fs2, fs3, de_cnt, vs_low, vs_fall, vs_edges);

        // Abort mid-frame on the small instance.
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            if (s_hp == 12'd5 && s_vp == 12'd3) found = 1;
        end
        chk("abort_reached", 32'(found), 32'd1);
        en_s = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("abort_de", 32'(s_de), 32'd0);
            chk("abort_syncs", 32'({s_hs, s_vs}), 32'd3);
        end
        en_s = 1'b1;
        step();
        chk("abort_restart_fs", 32'(s_fs), 32'd1);
        chk("abort_restart_pos", 32'({s_hp, s_vp}), 32'd0);
        $display("abort restart fs=%0b hp=%0d vp=%0d", s_fs, s_hp, s_vp);

`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
        reset = 1'b1; s_clr = 1'b0; step(); reset = 1'b0; step();
        chk("irq_after_release", 32'(s_irq), 32'd0);
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            if (s_hp == 12'd0 && s_vp == 12'(S_VA)) found = 1;
        end
        chk("irq_set_reached", 32'(found), 32'd1);
        chk("irq_set", 32'(s_irq), 32'd1);
        step();
        chk("irq_sticky", 32'(s_irq), 32'd1);
        s_clr = 1'b1; step(); s_clr = 1'b0;
        chk("irq_cleared", 32'(s_irq), 32'd0);
        s_clr = 1'b1;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            if (s_hp == 12'd0 && s_vp == 12'(S_VA)) found = 1;
        end
        chk("irq_set_wins", 32'(s_irq), 32'd1);
        step();
        chk("irq_clr_after_set", 32'(s_irq), 32'd0);
        s_clr = 1'b0;
        $display("irq set/clear sequence done irq=%0b", s_irq);
`endif

        // Random run control on both instances, model compares every cycle.
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 999) == 0);
            en_d  = ($urandom_range(0, 499) != 0);
            en_s  = ($urandom_range(0, 299) != 0);
            s_clr = ($urandom_range(0, 7) == 0);
            step();
        end
        reset = 1'b0; en_d = 1'b1; en_s = 1'b1; s_clr = 1'b0;
        step();
        $display("random phase done t_s=%0d t_d=%0d", t_s, t_d);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
